// File: rtl/md_sequencer_pkg.sv
// Shared definitions for the multiply/divide sequencer: operation encodings
// and default busy durations for the modelled multiplier and divider.
package md_sequencer_pkg;

  // Full md_op encoding as presented by the EX stage (6 and 7 are unused).
  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } mdOpE;

  // Arithmetic subset latched while busy; equals the low two bits of mdOpE.
  typedef enum logic [1:0] {
    AR_MULT  = 2'd0,
    AR_MULTU = 2'd1,
    AR_DIV   = 2'd2,
    AR_DIVU  = 2'd3
  } arithOpE;

  localparam int DEF_MULT_CYCLES = 5;
  localparam int DEF_DIV_CYCLES  = 10;

  // True for the four operations that occupy the multiplier/divider.
  function automatic logic isArith(input logic [2:0] op);
    return (op[2] == 1'b0);
  endfunction

endpackage

// File: rtl/md_sequencer_calc.sv
// Combinational multiply/divide datapath. Produces the HI/LO pair for the
// latched operation and flags a zero divisor so the caller can skip commit.
module md_calc
  import md_sequencer_pkg::*;
(
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] hi_res,
  output logic [31:0] lo_res,
  output logic        div_zero
);

  logic signed [63:0] sProd;
  logic        [63:0] uProd;
  logic        [31:0] absA;
  logic        [31:0] absB;
  logic        [31:0] dividend;
  logic        [31:0] divisor;
  logic        [31:0] uQuot;
  logic        [31:0] uRem;

  // Both products in 64 bits; signed operands sign-extend to the full width.
  assign sProd = $signed(a) * $signed(b);
  assign uProd = {32'd0, a} * {32'd0, b};

  // Signed division runs on magnitudes so 0x80000000 / -1 cannot overflow:
  // the magnitude quotient 0x80000000 negates back to itself.
  assign absA = a[31] ? (32'd0 - a) : a;
  assign absB = b[31] ? (32'd0 - b) : b;

  // Shared unsigned divider; a zero divisor is replaced by 1 to keep the
  // result defined, the commit is suppressed via div_zero anyway.
  assign dividend = (op == AR_DIV) ? absA : a;
  assign divisor  = (op == AR_DIV) ? absB : b;
  assign uQuot    = dividend / ((divisor == 32'd0) ? 32'd1 : divisor);
  assign uRem     = dividend % ((divisor == 32'd0) ? 32'd1 : divisor);

  // Select and sign-correct the result for the requested operation.
  always_comb begin
    hi_res   = 32'd0;
    lo_res   = 32'd0;
    div_zero = 1'b0;
    case (op)
      AR_MULT: begin
        hi_res = sProd[63:32];
        lo_res = sProd[31:0];
      end
      AR_MULTU: begin
        hi_res = uProd[63:32];
        lo_res = uProd[31:0];
      end
      AR_DIV: begin
        div_zero = (b == 32'd0);
        lo_res   = (a[31] ^ b[31]) ? (32'd0 - uQuot) : uQuot;
        hi_res   = a[31] ? (32'd0 - uRem) : uRem;
      end
      default: begin
        div_zero = (b == 32'd0);
        lo_res   = uQuot;
        hi_res   = uRem;
      end
    endcase
  end

endmodule

// File: rtl/md_sequencer.sv
// Multi-cycle MD sequencer: accepts MULT/MULTU/DIV/DIVU, counts down a fixed
// latency, then commits to the architectural HI/LO. MTHI/MTLO write directly.
module md_sequencer
  import md_sequencer_pkg::*;
#(
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        op_valid,
  input  logic [2:0]  md_op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        mf_req,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  logic [4:0]  countReg;
  logic [1:0]  opReg;
  logic [31:0] aReg;
  logic [31:0] bReg;
  logic [31:0] hiReg;
  logic [31:0] loReg;

  logic [31:0] hiRes;
  logic [31:0] loRes;
  logic        divZero;
  logic        accept;
  logic        commit;
  logic [4:0]  loadCount;

  assign busy   = (countReg != 5'd0);
  assign stall  = busy & (op_valid | mf_req);
  assign accept = ~busy & op_valid & isArith(md_op);
  assign commit = (countReg == 5'd1) & ~divZero;
  assign hi     = hiReg;
  assign lo     = loReg;

  // md_op[1] separates divides from multiplies.
  assign loadCount = md_op[1] ? 5'(DIV_CYCLES) : 5'(MULT_CYCLES);

  md_calc uCalc (
    .op       (opReg),
    .a        (aReg),
    .b        (bReg),
    .hi_res   (hiRes),
    .lo_res   (loRes),
    .div_zero (divZero)
  );

  // Latency counter: load on accept, then count down to idle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      countReg <= 5'd0;
    else if (accept)
      countReg <= loadCount;
    else if (busy)
      countReg <= countReg - 5'd1;
  end

  // Capture operation and operands so the result ignores later EX traffic.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      opReg <= 2'd0;
      aReg  <= 32'd0;
      bReg  <= 32'd0;
    end else if (accept) begin
      opReg <= md_op[1:0];
      aReg  <= src_a;
      bReg  <= src_b;
    end
  end

  // HI/LO: commit on the final busy edge, or direct moves while idle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hiReg <= 32'd0;
      loReg <= 32'd0;
    end else if (busy) begin
      if (commit) begin
        hiReg <= hiRes;
        loReg <= loRes;
      end
    end else if (op_valid) begin
      if (md_op == MD_MTHI) hiReg <= src_a;
      if (md_op == MD_MTLO) loReg <= src_a;
    end
  end

endmodule

// File: tb/tb_md_sequencer.sv
// Self-checking bench for md_sequencer: directed scenarios plus random ops,
// compared against a 64-bit arithmetic reference of HI/LO behaviour.
module tb_md_sequencer;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        op_valid = 1'b0;
  logic [2:0]  md_op = 3'd0;
  logic [31:0] src_a = 32'd0;
  logic [31:0] src_b = 32'd0;
  logic        mf_req = 1'b0;
  logic        busy;
  logic        stall;
  logic [31:0] hi;
  logic [31:0] lo;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] expHi = 32'd0;
  logic [31:0] expLo = 32'd0;

  md_sequencer #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .op_valid (op_valid),
    .md_op    (md_op),
    .src_a    (src_a),
    .src_b    (src_b),
    .mf_req   (mf_req),
    .busy     (busy),
    .stall    (stall),
    .hi       (hi),
    .lo       (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkBit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Reference HI/LO after an operation, from plain 64-bit arithmetic.
  function automatic logic [63:0] refMd(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [31:0] h,
                                        input logic [31:0] l);
    longint          sa, sb, sp, sq, sr;
    longint unsigned ua, ub, up;
    logic [63:0]     r;
    r  = {h, l};
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      3'd0: begin sp = sa * sb; r = sp; end
      3'd1: begin up = ua * ub; r = up; end
      3'd2: if (b != 32'd0) begin
        sq = sa / sb;
        sr = sa % sb;
        r  = {sr[31:0], sq[31:0]};
      end
      3'd3: if (b != 32'd0) begin
        up = ua / ub;
        sp = longint'(ua % ub);
        r  = {sp[31:0], up[31:0]};
      end
      3'd4: r = {a, l};
      3'd5: r = {h, a};
      default: r = {h, l};
    endcase
    return r;
  endfunction

  function automatic int latency(input logic [2:0] op);
    if (op == 3'd0 || op == 3'd1) return MC;
    if (op == 3'd2 || op == 3'd3) return DC;
    return 0;
  endfunction

  // Issue one op at the current (post-negedge) point. Optionally hold mf_req
  // during busy, and optionally present a second op while busy (must be
  // ignored). Returns at the first idle cycle.
  task automatic doOp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic mf, input logic pres, input logic [2:0] op2,
                      input logic [31:0] a2, input logic [31:0] b2);
    int          n;
    logic [63:0] r;
    n = latency(op);
    r = refMd(op, a, b, expHi, expLo);
    op_valid = 1'b1; md_op = op; src_a = a; src_b = b; mf_req = mf;
    #1;
    checkBit("accept_stall", stall, 1'b0);
    checkBit("accept_busy", busy, 1'b0);
    check("accept_hi", hi, expHi);
    check("accept_lo", lo, expLo);
    @(negedge clk);
    op_valid = pres; md_op = op2; src_a = a2; src_b = b2;
    for (int i = 0; i < n; i++) begin
      #1;
      checkBit("busy_high", busy, 1'b1);
      checkBit("busy_stall", stall, mf | pres);
      check("busy_hi", hi, expHi);
      check("busy_lo", lo, expLo);
      @(negedge clk);
    end
    expHi = r[63:32];
    expLo = r[31:0];
    #1;
    checkBit("idle_busy", busy, 1'b0);
    checkBit("idle_stall", stall, 1'b0);
    check("result_hi", hi, expHi);
    check("result_lo", lo, expLo);
    if (!pres) op_valid = 1'b0;
    mf_req = 1'b0;
    $display("op=%0d a=%h b=%h -> hi=%h lo=%h", op, a, b, hi, lo);
  endtask

  initial begin
    logic [2:0]  rop;
    logic [31:0] ra, rb;
    logic        rmf;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    checkBit("rst_busy", busy, 1'b0);
    checkBit("rst_stall", stall, 1'b0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // MULT -1 * 2, no requests
    doOp(3'd0, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    check("mult_hi_const", hi, 32'hFFFF_FFFF);
    check("mult_lo_const", lo, 32'hFFFF_FFFE);

    // MULTU with mf_req held during busy
    doOp(3'd1, 32'hFFFF_FFFF, 32'd2, 1'b1, 1'b0, 3'd0, 32'd0, 32'd0);
    check("multu_hi_const", hi, 32'h0000_0001);

    // DIV -7 / 2
    doOp(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    check("div_lo_const", lo, 32'hFFFF_FFFD);
    check("div_hi_const", hi, 32'hFFFF_FFFF);

    // DIVU by zero leaves HI/LO
    doOp(3'd3, 32'd7, 32'd0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    check("divz_hi_const", hi, 32'hFFFF_FFFF);

    // DIV overflow corner
    doOp(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    check("divovf_lo_const", lo, 32'h8000_0000);
    check("divovf_hi_const", hi, 32'd0);

    // Second MULT presented while busy: ignored, then accepted once idle
    doOp(3'd0, 32'd3, 32'd5, 1'b0, 1'b1, 3'd0, 32'd6, 32'd7);
    doOp(3'd0, 32'd6, 32'd7, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    check("second_mult_lo", lo, 32'd42);

    // MTHI then MTLO on consecutive cycles, then an ignored op code
    doOp(3'd4, 32'h1234_5678, 32'd0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    doOp(3'd5, 32'h9ABC_DEF0, 32'd0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    check("mthi_const", hi, 32'h1234_5678);
    check("mtlo_const", lo, 32'h9ABC_DEF0);
    doOp(3'd6, 32'hDEAD_BEEF, 32'd1, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    doOp(3'd7, 32'hCAFE_F00D, 32'd1, 1'b1, 1'b0, 3'd0, 32'd0, 32'd0);

    // Random operations
    for (int k = 0; k < 30; k++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 9));
      rmf = 1'($urandom_range(0, 1));
      doOp(rop, ra, rb, rmf, 1'b0, 3'd0, 32'd0, 32'd0);
    end

    // Reset in the middle of a DIV: nothing committed afterwards
    op_valid = 1'b1; md_op = 3'd2; src_a = 32'd100; src_b = 32'd3;
    @(negedge clk);
    op_valid = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checkBit("pre_rst_busy", busy, 1'b1);
    #1;
    reset_n = 1'b0;
    #1;
    expHi = 32'd0;
    expLo = 32'd0;
    checkBit("midrst_busy", busy, 1'b0);
    check("midrst_hi", hi, expHi);
    check("midrst_lo", lo, expLo);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      #1;
      checkBit("postrst_busy", busy, 1'b0);
      check("postrst_hi", hi, expHi);
      check("postrst_lo", lo, expLo);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/md_sequencer.md
# md_sequencer

Multi-cycle multiply/divide sequencer for the pipelined MIPS core, sitting beside the EX-stage ALU. It accepts one MULT/MULTU/DIV/DIVU/MTHI/MTLO operation per issue and models a fixed-latency multiplier/divider with a down-counter. It owns the architectural HI/LO registers and raises a stall request while busy, so the hazard unit can hold back later MD instructions and MFHI/MFLO reads.

## Interface
- `MULT_CYCLES`, default 5: busy duration for MULT/MULTU; legal range 1..31.
- `DIV_CYCLES`, default 10: busy duration for DIV/DIVU; legal range 1..31.
- `clk`  in  1  rising-edge clock.
- `reset_n`  in  1  reset, asynchronous, active-low.
- `op_valid`  in  1  MD instruction present in EX this cycle.
- `md_op`  in  3  operation: MULT=0, MULTU=1, DIV=2, DIVU=3, MTHI=4, MTLO=5; 6 and 7 are ignored.
- `src_a`  in  32  rs value; dividend or multiplicand; MTHI/MTLO data.
- `src_b`  in  32  rt value; divisor or multiplier.
- `mf_req`  in  1  MFHI/MFLO present in EX this cycle.
- `busy`  out  1  operation in flight (`count != 0`).
- `stall`  out  1  combinational: `busy & (op_valid | mf_req)`.
- `hi`  out  32  committed HI (registered).
- `lo`  out  32  committed LO (registered).

## Operation
- State: 5-bit `count`, latched op (2 bits), latched operands (32+32), `hi`, `lo`.
- Idle (`count==0`):
  - `op_valid` with MULT/MULTU/DIV/DIVU loads `count` with MULT_CYCLES or DIV_CYCLES and latches op and operands.
  - MTHI/MTLO writes `src_a` to `hi`/`lo` on that same edge; `count` stays 0.
  - Op codes 6 and 7 are ignored.
- Busy (`count!=0`):
  - `op_valid` is ignored, and `stall` is asserted so the pipeline re-presents the instruction.
  - `count` decrements each edge.
  - On the edge where `count==1`, the result is committed to `hi`/`lo` and `count` becomes 0.
- Arithmetic is computed from the latched operands only:
  - MULT: signed 32x32 -> 64; `hi`=[63:32], `lo`=[31:0].
  - MULTU: unsigned 32x32 -> 64, same split as MULT.
  - DIV: signed; `lo`=quotient truncated toward zero, `hi`=remainder with the sign of the dividend.
  - DIVU: unsigned quotient and remainder.
- Division corner cases:
  - Divisor 0 (DIV or DIVU): `hi`/`lo` are left unchanged at commit; busy timing is unaffected.
  - DIV of 0x80000000 by 0xFFFFFFFF: `lo`=0x80000000, `hi`=0.
- Reset mid-operation: `count`=0, `hi`=`lo`=0, latched op and operands cleared. The in-flight result is discarded and never committed.

## Timing
- Reset values: `busy`=0, `stall`=0 (given `busy`=0), `hi`=0, `lo`=0.
- Accept at edge E: `busy` is high for exactly N cycles after E (N = MULT_CYCLES or DIV_CYCLES).
  - New `hi`/`lo` are visible in the first cycle `busy` is low, i.e. after edge E+N.
- A new MD op may be accepted on edge E+N+1 at the earliest. There is no back-to-back overlap.
- MTHI/MTLO latency: 1 edge; the value is visible the next cycle.
- An `mf_req` in the accept cycle itself is not stalled. It reads the pre-operation HI/LO. The hazard unit ensures program order.
- `stall` is purely combinational from `busy`, `op_valid` and `mf_req`. There is no path from `src_a`/`src_b`.

## Structure
- `md_op` encodings and the MULT/DIV cycle defaults go in the shared `Constants.v` as macros, alongside the existing opcode and funct constants.
- One sub-module, `md_calc`: combinational arithmetic (op, a, b) -> {hi_res, lo_res, div_zero}.
  - `md_sequencer` instantiates it on the latched operands.
  - The counter, HI/LO registers and commit logic stay in `md_sequencer`.

## Test plan
- Reset, then MULT with a=0xFFFFFFFF, b=2 -> `busy` high for 5 cycles, `stall` low throughout if no request; then `hi`=0xFFFFFFFF, `lo`=0xFFFFFFFE.
- MULTU with a=0xFFFFFFFF, b=2 -> `hi`=0x00000001, `lo`=0xFFFFFFFE; `mf_req` asserted during busy -> `stall`=1 each busy cycle, 0 after.
- DIV with a=-7, b=2 -> 10 busy cycles; `lo`=0xFFFFFFFD (-3), `hi`=0xFFFFFFFF (-1). DIVU with a=7, b=0 -> HI/LO unchanged after 10 cycles.
- DIV with a=0x80000000, b=0xFFFFFFFF -> `lo`=0x80000000, `hi`=0. Second MULT presented while busy -> ignored, `stall`=1; accepted on the first idle cycle.
- MTHI 0x12345678, then MTLO 0x9ABCDEF0 on consecutive cycles -> `hi`/`lo` update one edge each; `busy` never rises.
- Start DIV, assert `reset_n`=0 at busy cycle 4 -> `busy`, `hi`, `lo` immediately 0; after release, no late commit occurs.
